// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the BTB branch predictor
package branch_predictor_pkg;

    typedef logic [31:0] word_t;

    // 2-bit saturating counter; MSB set means predict taken
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_cnt_t;

    typedef struct packed {
        logic    valid;
        word_t   tag;
        word_t   target;
        bp_cnt_t cnt;
    } bp_entry_t;

    localparam int BP_ENTRIES = 16;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - predictor-to-hazard-unit correction bundle
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic  mispredict;
    word_t correct_pc;

    modport bp     (output mispredict, output correct_pc);
    modport hazard (input  mispredict, input  correct_pc);

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - next value of a 2-bit saturating branch counter
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bp_cnt_t i_cnt,
    input  logic    i_taken,
    output bp_cnt_t o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != STRONG_T) o_cnt = bp_cnt_t'(i_cnt + 2'd1);
        end else begin
            if (i_cnt != STRONG_NT) o_cnt = bp_cnt_t'(i_cnt - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with resolve-side mispredict check
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t fetch_pc,
    output logic  predict_taken,
    output word_t predict_target,
    input  logic  resolve_valid,
    input  logic  resolve_isjump,
    input  word_t resolve_pc,
    input  logic  resolve_taken,
    input  word_t resolve_target,
    input  logic  resolve_pred_taken,
    input  word_t resolve_pred_target,
    input  logic  update_en,
    output logic  mispredict,
    output word_t correct_pc
`ifdef BP_STATS_EN
    ,
    output word_t stat_branches,
    output word_t stat_mispredicts
`endif
);

    localparam int TAG_SHIFT = IDXW + 2;

    bp_entry_t       r_tbl [ENTRIES];

    logic [IDXW-1:0] w_f_idx;
    logic [IDXW-1:0] w_r_idx;
    word_t           w_f_tag;
    word_t           w_r_tag;
    bp_entry_t       w_f_ent;
    bp_entry_t       w_r_ent;
    logic            w_f_hit;
    logic            w_r_hit;
    logic            w_wr;
    bp_cnt_t         w_next_cnt;
    bp_cnt_t         w_alloc_cnt;

    assign w_f_idx = fetch_pc[IDXW+1:2];
    assign w_r_idx = resolve_pc[IDXW+1:2];
    assign w_f_tag = fetch_pc >> TAG_SHIFT;
    assign w_r_tag = resolve_pc >> TAG_SHIFT;
    assign w_f_ent = r_tbl[w_f_idx];
    assign w_r_ent = r_tbl[w_r_idx];
    assign w_f_hit = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
    assign w_r_hit = w_r_ent.valid && (w_r_ent.tag == w_r_tag);

    // Lookup reads the stored entry directly, so a same-cycle update is not visible yet
    assign predict_taken  = w_f_hit & w_f_ent.cnt[1];
    assign predict_target = predict_taken ? w_f_ent.target : pc_plus4(fetch_pc);

    assign mispredict = resolve_valid &
                        ((resolve_taken != resolve_pred_taken) |
                         (resolve_taken & (resolve_pred_target != resolve_target)));
    assign correct_pc = resolve_taken ? resolve_target : pc_plus4(resolve_pc);

    assign w_wr        = resolve_valid & update_en;
    assign w_alloc_cnt = resolve_isjump ? STRONG_T : WEAK_T;

    sat_counter2 u_sat_counter2 (
        .i_cnt   (w_r_ent.cnt),
        .i_taken (resolve_taken),
        .o_cnt   (w_next_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
            end
        end else if (w_wr) begin
            if (w_r_hit) begin
                r_tbl[w_r_idx].cnt <= w_next_cnt;
                if (resolve_taken) r_tbl[w_r_idx].target <= resolve_target;
            end else if (resolve_taken) begin
                r_tbl[w_r_idx] <= '{valid: 1'b1, tag: w_r_tag,
                                    target: resolve_target, cnt: w_alloc_cnt};
            end
        end
    end

`ifdef BP_STATS_EN
    word_t r_stat_branches;
    word_t r_stat_mispredicts;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_wr) begin
            if (r_stat_branches != 32'hFFFF_FFFF)
                r_stat_branches <= r_stat_branches + 32'd1;
            if (mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution checker; sits upstream of the hazard unit.
- Fetch side: direct-mapped branch target buffer (BTB) lookup with 2-bit saturating counters gives next-PC prediction.
- Resolve side: compares actual branch/jump outcome against the carried prediction, drives `mispredict` and the correction PC into the hazard unit, and trains the table.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDXW, $clog2(ENTRIES), index width.
  - Index = pc[IDXW+1:2].
  - Tag = pc[31:IDXW+2].

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- fetch_pc  in  32  PC being fetched.
- predict_taken  out  1  BTB hit and counter MSB=1.
- predict_target  out  32  predicted target when predict_taken, else fetch_pc+4.
- resolve_valid  in  1  resolving stage holds a control-flow instruction this cycle.
- resolve_isjump  in  1  unconditional jump (J/JAL/JR).
- resolve_pc  in  32  PC of resolving instruction.
- resolve_taken  in  1  actual outcome; forced 1 for jumps.
- resolve_target  in  32  actual taken target.
- resolve_pred_taken  in  1  prediction carried down the pipe.
- resolve_pred_target  in  32  predicted target carried down the pipe.
- update_en  in  1  hazard-unit stage enable (EMen); table trains only when high.
- mispredict  out  1  to hazard unit.
- correct_pc  out  32  resolve_taken ? resolve_target : resolve_pc+4.

Behaviour:
- Lookup path is purely combinational: same-cycle prediction for fetch_pc.
- Hit = entry valid and tag match. Miss → predict_taken=0, predict_target=fetch_pc+4.
- mispredict = resolve_valid & ((resolve_taken != resolve_pred_taken) | (resolve_taken & resolve_pred_target != resolve_target)).
  - Combinational; 0 whenever resolve_valid=0.
- Table write occurs on the rising CLK edge when resolve_valid & update_en.
  - Hit, taken: counter increments, saturating at 2'b11; target overwritten.
  - Hit, not taken: counter decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate/replace entry; valid=1, tag set, target set.
    - Counter = 2'b11 for a jump, else 2'b10.
  - Miss, not taken: no allocation, table unchanged.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- update_en=0 with resolve_valid=1: mispredict and correct_pc still driven; table not written. Stalled instructions therefore train exactly once.
- Same-index lookup and update in one cycle: lookup returns the pre-update entry; no bypass.
- Reset (nRST low at an edge):
  - All entries: valid=0, counters=2'b01, tags/targets 0.
  - Outputs then follow combinationally: predict_taken=0, predict_target=fetch_pc+4, mispredict=0.
  - Reset mid-update: reset wins and the write is dropped.
- Arithmetic: all +4 additions are 32-bit, wrap modulo 2^32 (0xFFFFFFFC+4=0).
- Index/tag aliasing accepted: tag mismatch = miss.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined:
  - Extra outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Each increments on edges where resolve_valid & update_en (mispredicts additionally require mispredict=1).
  - Both saturate at 0xFFFFFFFF; reset to 0 with nRST.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- cpu_types_pkg additions:
  - word_t (32-bit).
  - bp_cnt_t enum {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T}.
  - bp_entry_t packed struct {valid, tag, target, cnt}.
  - localparam BP_ENTRIES=16.
- Interface: branch_predictor_if with modports bp and hazard, per existing practice.
- One natural sub-module: sat_counter2.
  - Pure function of (cnt, taken).
  - Instantiated once on the update path.

Test Plan:
- Reset, fetch_pc=0x100 → predict_taken=0, predict_target=0x104; mispredict=0.
- Resolve taken beq pc=0x100 target=0x200, pred_taken=0, update_en=1 → mispredict=1, correct_pc=0x200.
  - Next cycle fetch_pc=0x100 → predict_taken=1, predict_target=0x200.
- Same branch resolves not-taken twice (pred_taken=1 first) → counter 10→01→00.
  - First resolution: mispredict=1, correct_pc=0x104.
  - Afterwards: predict_taken=0 for 0x100.
- Four taken resolutions on a hit → counter saturates at 11; fifth taken leaves 11.
- resolve_valid=1, update_en=0, taken miss at 0x300 → mispredict=1; subsequent lookup of 0x300 still misses.
- Aliasing: train 0x100 taken, then resolve 0x140 (same index, 16 entries) taken target 0x400.
  - Lookup 0x100 → miss (predict_target=0x104); lookup 0x140 → predict 0x400.
- BP_STATS_EN: 3 resolutions including 1 mispredict → stat_branches=3, stat_mispredicts=1; nRST low → both 0.
